// File: rtl/vga_sync_timing.sv
// VGA raster timing: pixel-rate enable, x/y scan counters, sync pulses and blanked colour.
// hsync, vsync and rgb_out are registered together so they reach the connector aligned.
module vga_sync_timing #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_ACT  = 1'b0
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic [11:0] rgb_in,
    output logic        pixel_tick,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        in_display_area,
    output logic        line_end,
    output logic        frame_end,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb_out
);

    // Totals must stay <= 1024 so the 10-bit counters wrap exactly.
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_cnt;

    assign pixel_tick      = (div_cnt == DIV_LAST);
    assign in_display_area = (x < H_VIS) && (y < V_VIS);
    assign line_end        = pixel_tick && (x == H_LAST);
    assign frame_end       = line_end && (y == V_LAST);

    // Sync and colour are decoded from pre-increment counters, so they trail x/y by one pixel.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            div_cnt <= '0;
            x       <= '0;
            y       <= '0;
            hsync   <= ~SYNC_ACT;
            vsync   <= ~SYNC_ACT;
            rgb_out <= '0;
        end else begin
            div_cnt <= pixel_tick ? '0 : div_cnt + 1'b1;
            if (pixel_tick) begin
                if (x == H_LAST) begin
                    x <= '0;
                    y <= (y == V_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                hsync   <= (x >= HS_START && x < HS_END) ? SYNC_ACT : ~SYNC_ACT;
                vsync   <= (y >= VS_START && y < VS_END) ? SYNC_ACT : ~SYNC_ACT;
                rgb_out <= in_display_area ? rgb_in : 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_timing.sv
// Directed bench for vga_sync_timing: full 640x480 line timing plus a shrunken
// active-high-sync instance that makes frame/vsync wrap reachable in a short run.
module tb_vga_sync_timing;

    logic        clk;
    logic        reset;
    logic [11:0] rgb_in;
    logic        pixel_tick, in_display_area, line_end, frame_end, hsync, vsync;
    logic [9:0]  x, y;
    logic [11:0] rgb_out;

    logic        reset_s;
    logic [11:0] rgb_in_s;
    logic        pixel_tick_s, in_display_area_s, line_end_s, frame_end_s, hsync_s, vsync_s;
    logic [9:0]  x_s, y_s;
    logic [11:0] rgb_out_s;

    int checks   = 0;
    int failures = 0;
    int stray    = 0;

    vga_sync_timing dut (
        .clk_100MHz      (clk),
        .reset           (reset),
        .rgb_in          (rgb_in),
        .pixel_tick      (pixel_tick),
        .x               (x),
        .y               (y),
        .in_display_area (in_display_area),
        .line_end        (line_end),
        .frame_end       (frame_end),
        .hsync           (hsync),
        .vsync           (vsync),
        .rgb_out         (rgb_out)
    );

    // 15x8 raster, divide-by-3, active-high sync: hsync x 10..12, vsync y 5..6.
    vga_sync_timing #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_ACT(1'b1)
    ) dut_s (
        .clk_100MHz      (clk),
        .reset           (reset_s),
        .rgb_in          (rgb_in_s),
        .pixel_tick      (pixel_tick_s),
        .x               (x_s),
        .y               (y_s),
        .in_display_area (in_display_area_s),
        .line_end        (line_end_s),
        .frame_end       (frame_end_s),
        .hsync           (hsync_s),
        .vsync           (vsync_s),
        .rgb_out         (rgb_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next pixel tick of the full-size instance, scrambling rgb_in in between.
    task automatic next_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!pixel_tick) begin
                rgb_in = 12'($urandom);
                if (line_end || frame_end) stray++;
            end
        end while (!pixel_tick && n < 8);
        chk("tick_gap", 32'(n), 32'd4);
    endtask

    task automatic next_tick_s();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!pixel_tick_s) begin
                rgb_in_s = 12'($urandom);
                if (line_end_s || frame_end_s) stray++;
            end
        end while (!pixel_tick_s && n < 8);
        chk("tick_gap_s", 32'(n), 32'd3);
    endtask

    initial begin
        logic        exp_h, exp_v, done;
        logic [11:0] exp_rgb, pat;
        int          vs_high, fe_count;

        reset    = 1'b1;
        reset_s  = 1'b1;
        rgb_in   = 12'hFF0;
        rgb_in_s = 12'h000;

        // Reset state after 5 clocks of reset.
        repeat (5) @(negedge clk);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_tick", 32'(pixel_tick), 32'd0);
        reset = 1'b0;

        // First tick lands in the 4th clock after release.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("first_tick_phase", 32'(pixel_tick), (k == 2) ? 32'd1 : 32'd0);
        end

        // Line 0 with constant FF0, line 1 with a per-pixel pattern up to x=700.
        exp_h   = 1'b1;
        exp_rgb = 12'h000;
        done    = 1'b0;
        for (int ln = 0; ln < 2; ln++) begin
            for (int i = 0; i < 800; i++) begin
                if (!(ln == 0 && i == 0)) next_tick();
                chk("x", 32'(x), 32'(i));
                chk("y", 32'(y), 32'(ln));
                chk("hsync", 32'(hsync), 32'(exp_h));
                chk("vsync", 32'(vsync), 32'd1);
                chk("rgb_out", 32'(rgb_out), 32'(exp_rgb));
                chk("line_end", 32'(line_end), (i == 799) ? 32'd1 : 32'd0);
                chk("frame_end", 32'(frame_end), 32'd0);
                chk("in_display", 32'(in_display_area), (i < 640) ? 32'd1 : 32'd0);
                if (ln == 1 && i == 700) begin
                    done = 1'b1;
                    break;
                end
                pat     = (ln == 0) ? 12'hFF0 : 12'(i * 37 + 5);
                rgb_in  = pat;
                exp_rgb = (i < 640) ? pat : 12'h000;
                exp_h   = (i >= 656 && i < 752) ? 1'b0 : 1'b1;
            end
            if (done) break;
        end

        // One-clock reset in the middle of an hsync pulse.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_x", 32'(x), 32'd0);
        chk("mid_rst_y", 32'(y), 32'd0);
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vsync), 32'd1);
        chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
        chk("mid_rst_tick", 32'(pixel_tick), 32'd0);
        chk("mid_rst_line_end", 32'(line_end), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("resume_tick_phase", 32'(pixel_tick), (k == 2) ? 32'd1 : 32'd0);
        end
        chk("resume_x", 32'(x), 32'd0);
        chk("resume_y", 32'(y), 32'd0);
        rgb_in = 12'h123;
        next_tick();
        chk("resume_x1", 32'(x), 32'd1);
        chk("resume_hsync", 32'(hsync), 32'd1);
        chk("resume_rgb", 32'(rgb_out), 32'h123);

        // Small instance: reset state, then two full frames against hand-derived bounds.
        repeat (2) @(negedge clk);
        chk("s_rst_hsync", 32'(hsync_s), 32'd0);
        chk("s_rst_vsync", 32'(vsync_s), 32'd0);
        chk("s_rst_x", 32'(x_s), 32'd0);
        chk("s_rst_rgb", 32'(rgb_out_s), 32'h0);
        reset_s = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("s_tick_phase", 32'(pixel_tick_s), (k == 1) ? 32'd1 : 32'd0);
        end

        exp_h    = 1'b0;
        exp_v    = 1'b0;
        exp_rgb  = 12'h000;
        vs_high  = 0;
        fe_count = 0;
        for (int f = 0; f < 2; f++) begin
            for (int yy = 0; yy < 8; yy++) begin
                for (int xx = 0; xx < 15; xx++) begin
                    if (!(f == 0 && yy == 0 && xx == 0)) next_tick_s();
                    chk("s_x", 32'(x_s), 32'(xx));
                    chk("s_y", 32'(y_s), 32'(yy));
                    chk("s_in_display", 32'(in_display_area_s),
                        (xx < 8 && yy < 4) ? 32'd1 : 32'd0);
                    chk("s_line_end", 32'(line_end_s), (xx == 14) ? 32'd1 : 32'd0);
                    chk("s_frame_end", 32'(frame_end_s), (xx == 14 && yy == 7) ? 32'd1 : 32'd0);
                    chk("s_hsync", 32'(hsync_s), 32'(exp_h));
                    chk("s_vsync", 32'(vsync_s), 32'(exp_v));
                    chk("s_rgb", 32'(rgb_out_s), 32'(exp_rgb));
                    if (vsync_s) vs_high++;
                    if (frame_end_s) fe_count++;
                    pat      = 12'(xx * 16 + yy + 12'h800);
                    rgb_in_s = pat;
                    exp_rgb  = (xx < 8 && yy < 4) ? pat : 12'h000;
                    exp_h    = (xx >= 10 && xx < 13);
                    exp_v    = (yy >= 5 && yy < 7);
                end
            end
        end
        next_tick_s();
        chk("s_wrap_x", 32'(x_s), 32'd0);
        chk("s_wrap_y", 32'(y_s), 32'd0);
        chk("s_vsync_ticks", 32'(vs_high), 32'd60);
        chk("s_frame_end_count", 32'(fe_count), 32'd2);
        chk("stray_pulse", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
